// File: rtl/score_reader_pkg.sv
// Shared types and constants for the decimal score reader.
// Optional feature macro: HIGH_SCORE_EN (best-score tracking).
package score_reader_pkg;

  localparam int SCORE_W_DEF = 16;
  localparam int NUM_DIGITS  = 5;
  localparam int BCD_W       = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Double-dabble correction: every nibble >= 5 gets +3 (4-bit add, no carry out).
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (acc[4*n +: 4] >= 4'd5) res[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/score_reader_if.sv
// Score/handshake/display bundle between the score counter side and the reader.
// Optional feature macro: HIGH_SCORE_EN adds collision, show_best and best.
interface score_reader_if #(parameter int SCORE_W = 16);
  logic [SCORE_W-1:0] score;
  logic               start;
  logic               busy;
  logic               done;
  logic [3:0]         bcd4, bcd3, bcd2, bcd1, bcd0;
  logic               ovf;
  logic [6:0]         hex4, hex3, hex2, hex1;
`ifdef HIGH_SCORE_EN
  logic               collision;
  logic               show_best;
  logic [SCORE_W-1:0] best;

  modport master (output score, start, collision, show_best,
                  input  busy, done, bcd4, bcd3, bcd2, bcd1, bcd0, ovf,
                         hex4, hex3, hex2, hex1, best);
  modport slave  (input  score, start, collision, show_best,
                  output busy, done, bcd4, bcd3, bcd2, bcd1, bcd0, ovf,
                         hex4, hex3, hex2, hex1, best);
`else
  modport master (output score, start,
                  input  busy, done, bcd4, bcd3, bcd2, bcd1, bcd0, ovf,
                         hex4, hex3, hex2, hex1);
  modport slave  (input  score, start,
                  output busy, done, bcd4, bcd3, bcd2, bcd1, bcd0, ovf,
                         hex4, hex3, hex2, hex1);
`endif
endinterface

// File: rtl/score_reader_dec_to_seven_seg.sv
// 4-bit decimal digit to active-low {g,f,e,d,c,b,a} segment pattern.
// Non-decimal codes blank the display.
import score_reader_pkg::*;

module dec_to_seven_seg (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Combinational segment lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_ZERO;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_reader.sv
// Samples the binary score on start, converts it to 5 BCD digits with a
// one-bit-per-cycle double-dabble engine, drives 4 seven-segment displays.
// Optional feature macro: HIGH_SCORE_EN (best-score register, show_best select).
import score_reader_pkg::*;

module score_reader #(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input logic           clock,
  input logic           aclr,
  score_reader_if.slave bus
);

  localparam int CNT_W = $clog2(SCORE_W);

  state_e                         state_q;
  logic [SCORE_W-1:0]             bin_q, bin_d;
  logic [BCD_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           busy_q, done_q;
  logic [NUM_DIGITS-1:0][3:0]     dig_q;
  logic [3:0][6:0]                seg;
  logic [SCORE_W-1:0]             src;

`ifdef HIGH_SCORE_EN
  logic               coll_q;
  logic [SCORE_W-1:0] best_q;

  // Track the best score on each rising edge of collision
  always_ff @(posedge clock) begin
    if (aclr) begin
      coll_q <= 1'b0;
      best_q <= '0;
    end else begin
      coll_q <= bus.collision;
      if (bus.collision && !coll_q && (bus.score > best_q)) best_q <= bus.score;
    end
  end

  assign src      = bus.show_best ? best_q : bus.score;
  assign bus.best = best_q;
`else
  assign src = bus.score;
`endif

  // One double-dabble step: adjust nibbles, then shift {bcd, bin} left by one
  always_comb begin
    {acc_d, bin_d} = {bcd_adjust(acc_q), bin_q} << 1;
  end

  // Conversion FSM with registered busy/done/digit outputs
  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_q   <= src;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(SCORE_W - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          if (cnt_q == '0) begin
            // Final step: publish the digits as the FSM enters DONE
            dig_q   <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Displays show the low four digits; hex1 is the ones digit
  for (genvar g = 0; g < 4; g++) begin : g_seg
    dec_to_seven_seg u_seg (
      .digit_i (dig_q[g]),
      .seg_o   (seg[g])
    );
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd0 = dig_q[0];
  assign bus.bcd1 = dig_q[1];
  assign bus.bcd2 = dig_q[2];
  assign bus.bcd3 = dig_q[3];
  assign bus.bcd4 = dig_q[4];
  assign bus.ovf  = |dig_q[4];
  assign bus.hex1 = seg[0];
  assign bus.hex2 = seg[1];
  assign bus.hex3 = seg[2];
  assign bus.hex4 = seg[3];

endmodule
